// File: rtl/ardisik_alu.sv
// ardisik_alu: small ALU with single-cycle add/sub/increment/compare and a
// sequential shift-add multiplier (one multiplier bit per clock, LSB first).
module ardisik_alu #(
   parameter int WIDTH = 8
) (
   input  logic             clk_in,
   input  logic             rst_in,
   input  logic             basla_in,
   input  logic [2:0]       islem_in,
   input  logic [WIDTH-1:0] s1_in,
   input  logic [WIDTH-1:0] s2_in,
   output logic [WIDTH-1:0] s_out,
   output logic             hazir_out,
   output logic             gecerli_out,
   output logic             tasma_out,
   output logic             sifir_out
);

   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

   typedef enum logic {
      BOS  = 1'b0,
      CARP = 1'b1
   } state_t;

   state_t               state_reg, state_next;
   logic [2*WIDTH-1:0]   acc_reg, acc_next;
   logic [2*WIDTH-1:0]   mcand_reg, mcand_next;
   logic [WIDTH-1:0]     mplier_reg, mplier_next;
   logic [CW-1:0]        cnt_reg, cnt_next;
   logic [WIDTH-1:0]     s_reg, s_next;
   logic                 tasma_reg, tasma_next;
   logic                 sifir_reg, sifir_next;
   logic                 gecerli_reg, gecerli_next;

   logic [WIDTH:0]       sum_ext;
   logic [WIDTH:0]       dif_ext;
   logic [WIDTH-1:0]     alu_res;
   logic                 alu_flag;
   logic                 is_mul;
   logic [2*WIDTH-1:0]   partial;

   // Single-cycle datapath: result and flag for the non-multiply opcodes.
   always_comb begin
      sum_ext  = {1'b0, s1_in} + {1'b0, s2_in};
      dif_ext  = {1'b0, s1_in} - {1'b0, s2_in};
      alu_res  = '0;
      alu_flag = 1'b0;
      is_mul   = (islem_in == 3'b011) || (islem_in == 3'b101);
      case (islem_in)
         3'b000: begin
            alu_res  = sum_ext[WIDTH-1:0];
            alu_flag = sum_ext[WIDTH];
         end
         3'b001: begin
            alu_res  = dif_ext[WIDTH-1:0];
            alu_flag = dif_ext[WIDTH];   // borrow out == (s1 < s2)
         end
         3'b010: begin
            alu_res  = s2_in + WIDTH'(1);
            alu_flag = &s2_in;
         end
         3'b100: begin
            alu_res  = WIDTH'(s1_in > s2_in);
            alu_flag = 1'b0;
         end
         default: begin
            alu_res  = '0;
            alu_flag = 1'b0;
         end
      endcase
   end

   // Next-state and datapath control: accept starts in BOS, iterate in CARP.
   always_comb begin
      state_next   = state_reg;
      acc_next     = acc_reg;
      mcand_next   = mcand_reg;
      mplier_next  = mplier_reg;
      cnt_next     = cnt_reg;
      s_next       = s_reg;
      tasma_next   = tasma_reg;
      sifir_next   = sifir_reg;
      gecerli_next = 1'b0;
      partial      = mplier_reg[0] ? (acc_reg + mcand_reg) : acc_reg;
      case (state_reg)
         BOS: begin
            if (basla_in) begin
               if (is_mul) begin
                  // Square uses s1 as its own multiplier.
                  state_next  = CARP;
                  acc_next    = '0;
                  mcand_next  = {{WIDTH{1'b0}}, s1_in};
                  mplier_next = islem_in[2] ? s2_in : s1_in;
                  cnt_next    = '0;
               end else begin
                  s_next       = alu_res;
                  tasma_next   = alu_flag;
                  sifir_next   = (alu_res == '0);
                  gecerli_next = 1'b1;
               end
            end
         end
         CARP: begin
            acc_next    = partial;
            mcand_next  = mcand_reg << 1;
            mplier_next = mplier_reg >> 1;
            cnt_next    = cnt_reg + CW'(1);
            // Last bit: the partial sum is the full product, publish it now.
            if (cnt_reg == CW'(WIDTH - 1)) begin
               state_next   = BOS;
               s_next       = partial[WIDTH-1:0];
               tasma_next   = |partial[2*WIDTH-1:WIDTH];
               sifir_next   = (partial[WIDTH-1:0] == '0);
               gecerli_next = 1'b1;
            end
         end
         default: begin
            state_next = BOS;
         end
      endcase
   end

   // State and datapath registers with asynchronous reset.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_reg   <= BOS;
         acc_reg     <= '0;
         mcand_reg   <= '0;
         mplier_reg  <= '0;
         cnt_reg     <= '0;
         s_reg       <= '0;
         tasma_reg   <= 1'b0;
         sifir_reg   <= 1'b1;
         gecerli_reg <= 1'b0;
      end else begin
         state_reg   <= state_next;
         acc_reg     <= acc_next;
         mcand_reg   <= mcand_next;
         mplier_reg  <= mplier_next;
         cnt_reg     <= cnt_next;
         s_reg       <= s_next;
         tasma_reg   <= tasma_next;
         sifir_reg   <= sifir_next;
         gecerli_reg <= gecerli_next;
      end
   end

   assign s_out       = s_reg;
   assign tasma_out   = tasma_reg;
   assign sifir_out   = sifir_reg;
   assign gecerli_out = gecerli_reg;
   assign hazir_out   = (state_reg == BOS);

endmodule

// File: doc/ardisik_alu.md
ARDISIK_ALU -- requirements
Module: ardisik_alu

Interface
REQ-001 Parameter WIDTH, default 8, operand and result width in bits; legal range 2..32.
REQ-002 clk_in  input  1  single clock; all state changes on rising edge.
REQ-003 rst_in  input  1  reset, asynchronous, active-high.
REQ-004 basla_in  input  1  start request; sampled on rising edge of clk_in.
REQ-005 islem_in  input  3  operation code; sampled with basla_in.
REQ-006 s1_in  input  WIDTH  operand 1; sampled with basla_in.
REQ-007 s2_in  input  WIDTH  operand 2; sampled with basla_in.
REQ-008 s_out  output  WIDTH  registered result; holds until next result or reset.
REQ-009 hazir_out  output  1  high when a new start is accepted.
REQ-010 gecerli_out  output  1  one-cycle pulse; s_out and flags are new.
REQ-011 tasma_out  output  1  registered carry/borrow/overflow flag of the last result.
REQ-012 sifir_out  output  1  registered flag, high when the last result is all zero.

Function
REQ-013 States BOS (idle), CARP (multiply iterating); hazir_out SHALL equal (state==BOS).
REQ-014 Start accepted at an edge where basla_in=1 and state==BOS; operands and opcode captured there.
REQ-015 basla_in while state==CARP SHALL be ignored, with no effect on operands, state or outputs.
REQ-016 000: s1+s2, low WIDTH bits; tasma = carry out.
REQ-017 001: s1-s2, modulo 2^WIDTH; tasma = borrow (s1<s2 unsigned).
REQ-018 010: s2+1, modulo 2^WIDTH; tasma = 1 iff s2 is all ones.
REQ-019 011: s1*s1, low WIDTH bits; tasma = 1 iff any of the upper WIDTH bits of the 2*WIDTH product is nonzero.
REQ-020 100: result 1 if s1>s2 unsigned, else 0; tasma = 0.
REQ-021 101: s1*s2, same width and tasma rules as 011.
REQ-022 110, 111: result 0, tasma 0; no latch or held value from earlier operations.
REQ-023 Ops 000,001,010,100,110,111: result, flags registered at the accepting edge; gecerli_out high for exactly the following cycle; state stays BOS.
REQ-024 Ops 011,101: accepting edge enters CARP; shift-add, one multiplier bit per edge, LSB first, 2*WIDTH-bit accumulator.
REQ-025 Multiply: at accepting edge + WIDTH, result and flags registered, state returns to BOS, gecerli_out high for the following cycle.
REQ-026 Multiply latency is exactly WIDTH cycles; hazir_out is low for exactly WIDTH cycles.
REQ-027 A start accepted at the edge where multiply completes is impossible; the earliest next start is the edge after completion.
REQ-028 sifir_out = (new s_out == 0), updated only together with s_out.
REQ-029 s_out, tasma_out, sifir_out unchanged between gecerli_out pulses; during CARP s_out keeps the previous result.
REQ-030 Back-to-back single-cycle starts on consecutive edges SHALL each produce a result and a gecerli_out pulse, giving a throughput of 1 per cycle.

Reset
REQ-031 rst_in=1 forces state BOS, s_out=0, tasma_out=0, sifir_out=1, gecerli_out=0, hazir_out=1, accumulator and counters cleared, immediately and without a clock.
REQ-032 Reset during CARP aborts the multiply; no gecerli_out pulse follows for the aborted operation.
REQ-033 The first start is accepted at the first rising edge after rst_in deasserts.

Verification (WIDTH=8)
REQ-034 Add: 000, s1=200, s2=100 -> next cycle s_out=0x2C, tasma=1, sifir=0, gecerli pulse 1 cycle.
REQ-035 Sub: 001, s1=5, s2=7 -> s_out=0xFE, tasma=1; then 100, s1=3, s2=3 -> s_out=0x00, sifir=1, tasma=0.
REQ-036 Square: 011, s1=15 -> hazir low 8 cycles, s_out=225, tasma=0; s1=16 -> s_out=0x00, tasma=1, sifir=1.
REQ-037 Multiply with busy start: 101, s1=12, s2=11 -> s_out=132 after 8 cycles; basla_in with 000 pulsed at cycle 3 -> ignored, exactly one gecerli pulse.
REQ-038 Reset mid-op: start 101, assert rst_in at cycle 4 -> outputs at reset values at once, no gecerli pulse, next add accepted at first edge after release.
REQ-039 Streaming and undefined ops: 000 then 010 (s2=0xFF) then 110 on consecutive edges -> three pulses, results 0x2C/0x00/0x00, tasma 1/1/0.
